tick_generator: RTL

Upstream rate stage for the lab counter. It converts the 6-bit `divideby` switch setting into a periodic one-cycle `enable2` strobe and a derived 24-bit `halfmax` limit. Both feed the downstream counter stage directly. A small FSM latches the setting on a load request, rejects a zero divide value, and pauses under `enable1`.

---
 rtl/tick_generator_if.sv | 21 ++
 rtl/tick_generator.sv | 84 ++++++++
 2 files changed

// File: rtl/tick_generator_if.sv
// Handshake bundle between the tick generator and its controller.
// Master drives the run/load controls; slave returns the tick and limit.
interface tick_generator_if;
  logic        enable1;
  logic        load;
  logic [5:0]  divideby;
  logic        enable2;
  logic [23:0] halfmax;
  logic        running;
  logic        err;

  modport master (
    output enable1, load, divideby,
    input  enable2, halfmax, running, err
  );

  modport slave (
    input  enable1, load, divideby,
    output enable2, halfmax, running, err
  );
endinterface

// File: rtl/tick_generator.sv
// Rate stage: turns a latched divide setting into a periodic one-cycle
// strobe and a saturated half-limit for the downstream counter.
module tick_generator #(
  parameter int unsigned BASE_DIV   = 50000,
  parameter logic [23:0] HALF_SCALE = 24'd4096
) (
  input  logic             clk,
  input  logic             reset,
  tick_generator_if.slave  bus
);

  localparam int BW = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t        state_q;
  logic [5:0]    n_lat_q;
  logic [BW-1:0] base_q;
  logic [5:0]    div_q;
  logic          enable2_q;
  logic [23:0]   halfmax_q;
  logic [23:0]   halfmax_d;
  logic [29:0]   prod;
  logic          accept;
  logic          base_last;
  logic          div_last;

  assign prod      = 30'(bus.divideby) * 30'(HALF_SCALE);
  assign accept    = bus.load & bus.enable1;
  assign base_last = (base_q == BW'(BASE_DIV - 1));
  assign div_last  = (div_q == n_lat_q - 6'd1);

  always_comb begin
    halfmax_d = prod[23:0];
    if (prod[29:24] != 6'd0) halfmax_d = 24'hFFFFFF;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      n_lat_q   <= '0;
      base_q    <= '0;
      div_q     <= '0;
      enable2_q <= 1'b0;
      halfmax_q <= '0;
    end else begin
      enable2_q <= 1'b0;
      if (accept) begin
        // A load always wins over a tick landing on the same edge.
        if (bus.divideby != 6'd0) begin
          n_lat_q   <= bus.divideby;
          halfmax_q <= halfmax_d;
          base_q    <= '0;
          div_q     <= '0;
          state_q   <= RUN;
        end else begin
          state_q   <= ERR;
        end
      end else if (state_q == RUN && bus.enable1) begin
        if (base_last) begin
          base_q <= '0;
          if (div_last) begin
            div_q     <= '0;
            enable2_q <= 1'b1;
          end else begin
            div_q <= div_q + 6'd1;
          end
        end else begin
          base_q <= base_q + BW'(1);
        end
      end
    end
  end

  assign bus.enable2 = enable2_q;
  assign bus.halfmax = halfmax_q;
  assign bus.running = (state_q == RUN);
  assign bus.err     = (state_q == ERR);

endmodule
